param_subtractor_pipe: RTL and testbench

Parameterized, pipelined two's-complement subtractor with valid tagging; it is the inverse-direction companion of the team's parameterized pipelined adder. It computes `diff = a - b - bin` over WIDTH bits. The operation is split into CHUNK-bit slices, one pipeline stage per slice, with the borrow registered between stages. It sits in the same datapath as the adder and is used for difference/compare paths that need full-rate throughput at high clock frequency.

---
 rtl/arith_pkg.sv | 18 +
 rtl/param_subtractor_pipe_if.sv | 28 ++
 rtl/sub_slice.sv | 19 +
 rtl/param_subtractor_pipe.sv | 150 +++++++++++++++
 tb/tb_param_subtractor_pipe.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic package: widths and stage helpers common to the pipelined
// adder and subtractor datapaths.
package arith_pkg;

   localparam int ARITH_DEFAULT_WIDTH = 8;
   localparam int ARITH_DEFAULT_CHUNK = 4;

   // Number of pipeline stages when WIDTH is cut into CHUNK-bit slices.
   function automatic int num_stages(input int width, input int chunk);
      return width / chunk;
   endfunction

   // True when the slicing is legal: at least one full slice and no remainder.
   function automatic bit width_is_valid(input int width, input int chunk);
      return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
   endfunction

endpackage

// File: rtl/param_subtractor_pipe_if.sv
// Operand/result bundle of the pipelined subtractor. The master drives operands
// and consumes results; the slave is the subtractor itself.
interface param_subtractor_pipe_if
   import arith_pkg::*;
#(
   parameter int WIDTH = ARITH_DEFAULT_WIDTH
);

   logic             valid_in;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             valid_out;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;

   modport master (
      output valid_in, a, b, bin,
      input  valid_out, diff, bout, ovf
   );

   modport slave (
      input  valid_in, a, b, bin,
      output valid_out, diff, bout, ovf
   );

endinterface

// File: rtl/sub_slice.sv
// Combinational CHUNK-bit subtractor slice with borrow in/out. The subtraction
// is done as a + ~b + ~borrow_in so the carry out is the inverted borrow.
module sub_slice #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             borrow_in,
   output logic [CHUNK-1:0] diff,
   output logic             borrow_out
);

   logic [CHUNK:0] sum;

   assign sum        = {1'b0, a} + {1'b0, ~b} + {{CHUNK{1'b0}}, ~borrow_in};
   assign diff       = sum[CHUNK-1:0];
   assign borrow_out = ~sum[CHUNK];

endmodule

// File: rtl/param_subtractor_pipe.sv
// Pipelined two's-complement subtractor: diff = a - b - bin, one CHUNK-bit
// slice per stage with the borrow registered between stages. Upper operand
// slices are skewed in, lower result slices are deskewed out, and every data
// register loads only when the valid bit travelling with it is set.
module param_subtractor_pipe
   import arith_pkg::*;
#(
   parameter int WIDTH = ARITH_DEFAULT_WIDTH,
   parameter int CHUNK = ARITH_DEFAULT_CHUNK
) (
   input  logic                    clk,
   input  logic                    rst,
   param_subtractor_pipe_if.slave  bus
);

   localparam int STAGES = num_stages(WIDTH, CHUNK);

   if (!width_is_valid(WIDTH, CHUNK)) begin : g_param_check
      $error("param_subtractor_pipe: WIDTH (%0d) must be a non-zero multiple of CHUNK (%0d)",
             WIDTH, CHUNK);
   end

   // v_in[k] qualifies the data entering stage k, v_q[k] the data leaving it.
   logic [STAGES-1:0] v_in;
   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] brw;
   logic              ovf_q;

   assign v_in[0] = bus.valid_in;

   for (genvar k = 1; k < STAGES; k++) begin : g_valid_link
      assign v_in[k] = v_q[k-1];
   end

   // Valid chain: bubbles shift through unchanged so ordering is preserved.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q <= '0;
      end else begin
         v_q <= v_in;
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [CHUNK-1:0] op_a;
      logic [CHUNK-1:0] op_b;
      logic [CHUNK-1:0] slice_diff;
      logic [CHUNK-1:0] res_q;
      logic             borrow_in;
      logic             slice_bout;
      logic             bout_q;

      if (k == 0) begin : g_direct
         assign op_a      = bus.a[CHUNK-1:0];
         assign op_b      = bus.b[CHUNK-1:0];
         assign borrow_in = bus.bin;
      end else begin : g_skew
         logic [CHUNK-1:0] a_sk [k];
         logic [CHUNK-1:0] b_sk [k];

         // Skew chain: delay operand slice k by k cycles, stepping with its operation.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int j = 0; j < k; j++) begin
                  a_sk[j] <= '0;
                  b_sk[j] <= '0;
               end
            end else begin
               if (v_in[0]) begin
                  a_sk[0] <= bus.a[k*CHUNK +: CHUNK];
                  b_sk[0] <= bus.b[k*CHUNK +: CHUNK];
               end
               for (int j = 1; j < k; j++) begin
                  if (v_in[j]) begin
                     a_sk[j] <= a_sk[j-1];
                     b_sk[j] <= b_sk[j-1];
                  end
               end
            end
         end

         assign op_a      = a_sk[k-1];
         assign op_b      = b_sk[k-1];
         assign borrow_in = brw[k-1];
      end

      sub_slice #(.CHUNK(CHUNK)) u_slice (
         .a          (op_a),
         .b          (op_b),
         .borrow_in  (borrow_in),
         .diff       (slice_diff),
         .borrow_out (slice_bout)
      );

      // Stage register: capture this slice's result and borrow for a valid operation.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            res_q  <= '0;
            bout_q <= 1'b0;
         end else if (v_in[k]) begin
            res_q  <= slice_diff;
            bout_q <= slice_bout;
         end
      end

      assign brw[k] = bout_q;

      if (k < STAGES - 1) begin : g_deskew
         localparam int DEPTH = STAGES - 1 - k;
         logic [CHUNK-1:0] dsk [DEPTH];

         // Deskew chain: hold back this low slice until the top slice is done.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int j = 0; j < DEPTH; j++) begin
                  dsk[j] <= '0;
               end
            end else begin
               if (v_in[k+1]) begin
                  dsk[0] <= res_q;
               end
               for (int j = 1; j < DEPTH; j++) begin
                  if (v_in[k+1+j]) begin
                     dsk[j] <= dsk[j-1];
                  end
               end
            end
         end

         assign bus.diff[k*CHUNK +: CHUNK] = dsk[DEPTH-1];
      end else begin : g_last
         // Signed overflow: operand signs differ and the result sign left the minuend's.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               ovf_q <= 1'b0;
            end else if (v_in[k]) begin
               ovf_q <= (op_a[CHUNK-1] != op_b[CHUNK-1]) &&
                        (slice_diff[CHUNK-1] != op_a[CHUNK-1]);
            end
         end

         assign bus.diff[k*CHUNK +: CHUNK] = res_q;
      end
   end

   assign bus.valid_out = v_q[STAGES-1];
   assign bus.bout      = brw[STAGES-1];
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_param_subtractor_pipe.sv
// Scoreboard bench for param_subtractor_pipe (WIDTH=8, CHUNK=4). Expected
// results are computed from a - b - bin when an operation is driven, and
// compared, including arrival edge, when valid_out is seen.
module tb_param_subtractor_pipe;

   localparam int WIDTH  = 8;
   localparam int CHUNK  = 4;
   localparam int STAGES = WIDTH / CHUNK;

   typedef struct {
      logic [WIDTH-1:0] diff;
      logic             bout;
      logic             ovf;
      int               edge_n;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int checks   = 0;
   int errors   = 0;
   int edge_cnt = 0;

   exp_t             sb[$];
   logic [WIDTH-1:0] last_diff = '0;
   logic             last_bout = 1'b0;
   logic             last_ovf  = 1'b0;

   param_subtractor_pipe_if #(.WIDTH(WIDTH)) bus ();

   param_subtractor_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Edge counter used to check result latency.
   always @(posedge clk) edge_cnt++;

   // Safety net so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drive one cycle of stimulus; valid operations get their result queued.
   task automatic apply_stimulus(input bit v, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic bin);
      logic [WIDTH:0] full;
      exp_t           e;
      @(posedge clk);
      #1;
      bus.valid_in = v;
      bus.a        = a;
      bus.b        = b;
      bus.bin      = bin;
      if (v) begin
         full     = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
         e.diff   = full[WIDTH-1:0];
         e.bout   = full[WIDTH];
         e.ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (e.diff[WIDTH-1] != a[WIDTH-1]);
         e.edge_n = edge_cnt + STAGES;
         sb.push_back(e);
      end
   endtask

   task automatic drain_outputs();
      apply_stimulus(1'b0, '0, '0, 1'b0);
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
      check_output("drain_empty", sb.size(), 0);
   endtask

   // Output monitor: compare valid results in order, otherwise check the hold.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (bus.valid_out) begin
            if (sb.size() == 0) begin
               check_output("unexpected_valid", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check_output("diff",    bus.diff, e.diff);
               check_output("bout",    bus.bout, e.bout);
               check_output("ovf",     bus.ovf,  e.ovf);
               check_output("latency", edge_cnt, e.edge_n);
               last_diff = e.diff;
               last_bout = e.bout;
               last_ovf  = e.ovf;
            end
         end else begin
            check_output("hold", {bus.bout, bus.ovf, bus.diff},
                         {last_bout, last_ovf, last_diff});
         end
      end
   end

   initial begin
      int issued;
      bus.valid_in = 1'b0;
      bus.a        = '0;
      bus.b        = '0;
      bus.bin      = 1'b0;

      // Reset held low with random activity on the inputs.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         bus.valid_in = 1'b1;
         bus.a        = WIDTH'($urandom);
         bus.b        = WIDTH'($urandom);
         bus.bin      = 1'($urandom);
         @(negedge clk);
         check_output("rst_valid", bus.valid_out, 0);
         check_output("rst_diff",  bus.diff, 0);
         check_output("rst_bout",  bus.bout, 0);
         check_output("rst_ovf",   bus.ovf, 0);
      end
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
      rst          = 1'b1;

      // Basic, slice-boundary borrow, borrow-in and overflow cases.
      apply_stimulus(1'b1, 8'h35, 8'h12, 1'b0);
      apply_stimulus(1'b1, 8'h10, 8'h01, 1'b0);
      apply_stimulus(1'b1, 8'h00, 8'h00, 1'b1);
      apply_stimulus(1'b1, 8'h80, 8'h01, 1'b0);
      apply_stimulus(1'b1, 8'h7F, 8'hFF, 1'b0);
      drain_outputs();

      // Back-to-back stream with one bubble.
      apply_stimulus(1'b1, 8'hC3, 8'h4A, 1'b0);
      apply_stimulus(1'b1, 8'h19, 8'h9E, 1'b1);
      apply_stimulus(1'b0, 8'hAA, 8'h55, 1'b1);
      apply_stimulus(1'b1, 8'h66, 8'h66, 1'b0);
      drain_outputs();

      // Short reset pulse with two operations in flight.
      apply_stimulus(1'b1, 8'h5A, 8'h3C, 1'b0);
      apply_stimulus(1'b1, 8'h11, 8'h22, 1'b1);
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
      check_output("pre_rst_valid", bus.valid_out, 1);
      rst = 1'b0;
      #1;
      check_output("rst_pulse_valid", bus.valid_out, 0);
      check_output("rst_pulse_diff",  bus.diff, 0);
      check_output("rst_pulse_bout",  bus.bout, 0);
      sb.delete();
      last_diff = '0;
      last_bout = 1'b0;
      last_ovf  = 1'b0;
      #1;
      rst = 1'b1;
      for (int i = 0; i < 5; i++) apply_stimulus(1'b0, '0, '0, 1'b0);

      // Random traffic with random bubbles.
      issued = 0;
      while (issued < 200) begin
         if ($urandom_range(0, 4) != 0) begin
            apply_stimulus(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            issued++;
         end else begin
            apply_stimulus(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
         end
      end
      drain_outputs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
